// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word and shifts it out MSB-first.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_tx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pl,
    input  logic [WIDTH-1:0] di,
    input  logic             en,
    output logic             ready,
    output logic             sdo,
    output logic             frame,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             last_bit_s;
    logic             final_s;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    assign last_bit_s = (state_q == S_SHIFT) && (cnt_q == LAST_CNT);

    // The final bit of a word is the parity bit when present, else the last data bit.
`ifdef PISO_PARITY_EN
    assign final_s = (state_q == S_PAR);
`else
    assign final_s = last_bit_s;
`endif

    // Combinational ready lets a new word follow the final bit with no idle gap.
    assign ready = reset & ((state_q == S_IDLE) | (final_s & en));
    assign done  = done_q;

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pl) begin
                    state_d = S_SHIFT;
                    sh_d    = di;
                    cnt_d   = '0;
`ifdef PISO_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (en) begin
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef PISO_PARITY_EN
                    par_d = par_q ^ sh_q[WIDTH-1];
                    if (last_bit_s) begin
                        state_d = S_PAR;
                    end else begin
                        state_d = S_SHIFT;
                    end
`else
                    if (last_bit_s) begin
                        done_d = 1'b1;
                        if (pl) begin
                            state_d = S_SHIFT;
                            sh_d    = di;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_SHIFT;
                    end
`endif
                end else begin
                    state_d = S_SHIFT;
                end
            end
`ifdef PISO_PARITY_EN
            S_PAR: begin
                if (en) begin
                    done_d = 1'b1;
                    if (pl) begin
                        state_d = S_SHIFT;
                        sh_d    = di;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_PAR;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                sh_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset wins over a load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Serial output and frame qualifier decoded from the registered state.
    always_comb begin
        sdo   = 1'b0;
        frame = 1'b0;
        case (state_q)
            S_SHIFT: begin
                sdo   = sh_q[WIDTH-1];
                frame = 1'b1;
            end
`ifdef PISO_PARITY_EN
            S_PAR: begin
                sdo   = par_q;
                frame = 1'b1;
            end
`endif
            default: begin
                sdo   = 1'b0;
                frame = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed scenarios plus randomized traffic against a
// bit-queue reference model (expected serial bits of the word in flight).
module tb_piso_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pl = 1'b0;
    logic [3:0] di = 4'd0;
    logic       en = 1'b0;
    logic       ready, sdo, frame, done;

    int checks = 0;
    int errors = 0;

    bit mq[$];
    bit m_done = 1'b0;
    bit exp_ready, exp_sdo, exp_frame, exp_done;

`ifdef PISO_PARITY_EN
    localparam int WORD_BITS = 5;
`else
    localparam int WORD_BITS = 4;
`endif

    piso_tx #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .pl    (pl),
        .di    (di),
        .en    (en),
        .ready (ready),
        .sdo   (sdo),
        .frame (frame),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic p, input logic [3:0] d, input logic e);
        @(negedge clk);
        reset = r;
        pl    = p;
        di    = d;
        en    = e;
        #1;
        exp_frame = (mq.size() != 0);
        exp_sdo   = exp_frame ? mq[0] : 1'b0;
        exp_ready = r && ((mq.size() == 0) || (mq.size() == 1 && e));
        exp_done  = m_done;
    endtask

    task automatic advance();
        bit rdy;
        rdy = exp_ready;
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            m_done = (mq.size() == 1) && en;
            if (en && mq.size() > 0) void'(mq.pop_front());
            if (rdy && pl) begin
                for (int i = 3; i >= 0; i--) mq.push_back(di[i]);
`ifdef PISO_PARITY_EN
                mq.push_back(($countones(di) % 2) == 1);
`endif
            end
        end
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 4'b1111, 1'b1);
        advance();
        for (int c = 0; c < 2; c++) begin
            drive(1'b0, 1'b1, 4'b1111, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d rdy/sdo/frm/done got %b want 0000", c, {ready, sdo, frame, done});
            end
            advance();
        end
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 4'b1111, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_release cyc %0d rdy/sdo/frm/done got %b want 1000", c, {ready, sdo, frame, done});
            end
            advance();
        end
    endtask

    task automatic test_single();
        logic [15:0] seq = '0;
        int nbits = 0;
        int ndone = 0;
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b10100;
`else
        want = 16'b1010;
`endif
        for (int c = 0; c < WORD_BITS + 3; c++) begin
            drive(1'b1, (c == 0), 4'b1010, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL single cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            if (frame) begin seq = {seq[14:0], sdo}; nbits++; end
            if (done) ndone++;
            advance();
        end
        checks++;
        if (seq !== want || nbits != WORD_BITS || ndone != 1) begin
            errors++;
            $display("FAIL single_seq got %b/%0d bits/%0d done want %b/%0d/1", seq, nbits, ndone, want, WORD_BITS);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq = '0;
        int nbits = 0;
        int ndone = 0;
        logic [15:0] want;
        logic [3:0] d;
`ifdef PISO_PARITY_EN
        want = 16'b10100_10111;
`else
        want = 16'b1010_1011;
`endif
        for (int c = 0; c < 2 * WORD_BITS + 3; c++) begin
            d = (c < WORD_BITS) ? 4'b1010 : 4'b1011;
            drive(1'b1, (c <= WORD_BITS), d, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL b2b cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            if (frame) begin seq = {seq[14:0], sdo}; nbits++; end
            if (done) ndone++;
            advance();
        end
        checks++;
        if (seq !== want || nbits != 2 * WORD_BITS || ndone != 2) begin
            errors++;
            $display("FAIL b2b_seq got %b/%0d bits/%0d done want %b/%0d/2", seq, nbits, ndone, want, 2 * WORD_BITS);
        end
    endtask

    task automatic test_stall();
        logic [15:0] seq = '0;
        int nbits = 0;
        int ndone = 0;
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b11111000;
`else
        want = 16'b1111100;
`endif
        for (int c = 0; c < WORD_BITS + 7; c++) begin
            drive(1'b1, (c <= 3), (c == 0) ? 4'b1100 : 4'b0101, !(c >= 1 && c <= 3));
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL stall cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            if (frame) begin seq = {seq[14:0], sdo}; nbits++; end
            if (done) ndone++;
            advance();
        end
        checks++;
        if (seq !== want || nbits != WORD_BITS + 3 || ndone != 1) begin
            errors++;
            $display("FAIL stall_seq got %b/%0d bits/%0d done want %b/%0d/1", seq, nbits, ndone, want, WORD_BITS + 3);
        end
    endtask

    task automatic test_abort();
        logic [15:0] seq = '0;
        int nbits = 0;
        int ndone = 0;
        logic [15:0] want;
`ifdef PISO_PARITY_EN
        want = 16'b10010;
`else
        want = 16'b1001;
`endif
        for (int c = 0; c < 4; c++) begin
            drive((c != 3), (c == 0), 4'b0110, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL abort cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            advance();
        end
        drive(1'b1, 1'b1, 4'b1001, 1'b1);
        checks++;
        if ({ready, sdo, frame, done} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_after rdy/sdo/frm/done got %b want 1000", {ready, sdo, frame, done});
        end
        advance();
        for (int c = 0; c < WORD_BITS + 2; c++) begin
            drive(1'b1, 1'b0, 4'b0000, 1'b1);
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL abort_reload cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            if (frame) begin seq = {seq[14:0], sdo}; nbits++; end
            if (done) ndone++;
            advance();
        end
        checks++;
        if (seq !== want || nbits != WORD_BITS || ndone != 1) begin
            errors++;
            $display("FAIL abort_seq got %b/%0d bits/%0d done want %b/%0d/1", seq, nbits, ndone, want, WORD_BITS);
        end
    endtask

    task automatic test_random();
        logic r, p, e;
        logic [3:0] d;
        for (int c = 0; c < 500; c++) begin
            r = ($urandom_range(0, 39) != 0);
            p = ($urandom_range(0, 1) == 1);
            e = ($urandom_range(0, 3) != 0);
            d = 4'($urandom);
            drive(r, p, d, e);
            checks++;
            if ({ready, sdo, frame, done} !== {exp_ready, exp_sdo, exp_frame, exp_done}) begin
                errors++;
                $display("FAIL random cyc %0d rdy/sdo/frm/done got %b want %b", c,
                         {ready, sdo, frame, done}, {exp_ready, exp_sdo, exp_frame, exp_done});
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
